// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: detects a key from an all-columns-low idle probe,
// scans columns to locate it, debounces press and release, and queues decoded
// key codes in a 4-entry first-word-fall-through FIFO.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_rd,
    output logic       pressed,
    output logic       overflow
);

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_MAX  = 4'(DEBOUNCE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  rs_meta, rs;
    logic [7:0]  dwell;
    logic [1:0]  col_idx, col_idx_nx;
    logic [3:0]  pat, pat_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [3:0]  cnt_inc;
    logic        sample;
    logic        one_low;
    logic        push;
    logic [3:0]  code_dec;

    logic [3:0]  mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        full;
    logic        pop;
    logic        wr_en;

    assign sample  = (dwell == DIV_LAST);
    assign cnt_inc = cnt + 4'd1;
    assign one_low = (rs == 4'b1110) || (rs == 4'b1101) ||
                     (rs == 4'b1011) || (rs == 4'b0111);

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_meta <= '1;
            rs      <= '1;
        end else begin
            rs_meta <= row;
            rs      <= rs_meta;
        end
    end

    // Dwell counter restarts whenever the state or scanned column moves
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell <= '0;
        end else if (sample || (state_nx != state) || (col_idx_nx != col_idx)) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + 8'd1;
        end
    end

    // FSM state and scan/debounce bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            col_idx <= '0;
            pat     <= '1;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            col_idx <= col_idx_nx;
            pat     <= pat_nx;
            cnt     <= cnt_nx;
        end
    end

    // Next-state logic, column drive and press indication
    always_comb begin
        state_nx   = state;
        col_idx_nx = col_idx;
        pat_nx     = pat;
        cnt_nx     = cnt;
        push       = 1'b0;
        col        = ~(4'b0001 << col_idx);
        pressed    = 1'b0;
        case (state)
            S_IDLE: begin
                col = '0;
                if (sample && (rs != 4'b1111)) begin
                    state_nx   = S_SCAN;
                    col_idx_nx = '0;
                end
            end
            S_SCAN: begin
                if (sample) begin
                    if (one_low) begin
                        state_nx = S_DEBOUNCE;
                        pat_nx   = rs;
                        cnt_nx   = '0;
                    end else if (col_idx == 2'd3) begin
                        state_nx   = S_IDLE;
                        col_idx_nx = '0;
                    end else begin
                        col_idx_nx = col_idx + 2'd1;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (sample) begin
                    if (rs == pat) begin
                        if (cnt_inc == DEB_MAX) begin
                            push     = 1'b1;
                            state_nx = S_HELD;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else begin
                        state_nx   = S_IDLE;
                        col_idx_nx = '0;
                        cnt_nx     = '0;
                    end
                end
            end
            S_HELD: begin
                pressed = 1'b1;
                if (sample && (rs == 4'b1111)) begin
                    state_nx = S_RELEASE;
                    cnt_nx   = '0;
                end
            end
            S_RELEASE: begin
                pressed = 1'b1;
                if (sample) begin
                    if (rs == 4'b1111) begin
                        if (cnt_inc == DEB_MAX) begin
                            state_nx   = S_IDLE;
                            col_idx_nx = '0;
                            cnt_nx     = '0;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else begin
                        state_nx = S_HELD;
                        cnt_nx   = '0;
                    end
                end
            end
            default: begin
                state_nx   = S_IDLE;
                col_idx_nx = '0;
                cnt_nx     = '0;
            end
        endcase
    end

    // Key decode from latched column index and row pattern
    always_comb begin
        code_dec = '0;
        case (col_idx)
            2'd0: case (pat)
                4'b0111: code_dec = 4'h1;
                4'b1011: code_dec = 4'h2;
                4'b1101: code_dec = 4'h3;
                4'b1110: code_dec = 4'hA;
                default: code_dec = '0;
            endcase
            2'd1: case (pat)
                4'b0111: code_dec = 4'hE;
                4'b1011: code_dec = 4'h0;
                4'b1101: code_dec = 4'hF;
                4'b1110: code_dec = 4'hD;
                default: code_dec = '0;
            endcase
            2'd2: case (pat)
                4'b0111: code_dec = 4'h7;
                4'b1011: code_dec = 4'h8;
                4'b1101: code_dec = 4'h9;
                4'b1110: code_dec = 4'hC;
                default: code_dec = '0;
            endcase
            default: case (pat)
                4'b0111: code_dec = 4'h4;
                4'b1011: code_dec = 4'h5;
                4'b1101: code_dec = 4'h6;
                4'b1110: code_dec = 4'hB;
                default: code_dec = '0;
            endcase
        endcase
    end

    assign full      = (count == 3'd4);
    assign key_valid = (count != 3'd0);
    assign pop       = key_rd && key_valid;
    assign wr_en     = push && (!full || pop);
    assign key_code  = key_valid ? mem[rd_ptr] : '0;

    // FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= code_dec;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a behavioural keypad drives the
// rows from the column drive, and a queue models the expected FIFO contents.
module tb_keypad_scan_ctrl;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_rd;
    logic [3:0]  row, col, key_code;
    logic        key_valid, pressed, overflow;
    logic [15:0] keys;

    int          vectors = 0;
    int          miscompares = 0;
    logic [3:0]  q [$];
    logic        ovf_exp;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_rd    (key_rd),
        .pressed   (pressed),
        .overflow  (overflow)
    );

    // Passive keypad: a held key at (r,c) pulls row r low while column c is low
    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    // Key position r*4+c on the matrix for each code
    function automatic int key_pos(input logic [3:0] code);
        case (code)
            4'h1: return 12; 4'h2: return 8;  4'h3: return 4;  4'hA: return 0;
            4'hE: return 13; 4'h0: return 9;  4'hF: return 5;  4'hD: return 1;
            4'h7: return 14; 4'h8: return 10; 4'h9: return 6;  4'hC: return 2;
            4'h4: return 15; 4'h5: return 11; 4'h6: return 7;  default: return 3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [3:0] code);
        if (q.size() < 4) q.push_back(code);
        else ovf_exp = 1'b1;
    endtask

    task automatic wait_pressed(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (pressed !== lvl && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (pressed !== lvl) begin
            miscompares++;
            $display("FAIL %s: pressed=%b required %b within %0d cycles", name, pressed, lvl, budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        keys = '0;
        key_rd = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        q.delete();
        ovf_exp = 1'b0;
    endtask

    task automatic press_key(input logic [3:0] code);
        keys = '0;
        keys[key_pos(code)] = 1'b1;
        wait_pressed(1'b1, 200, "press_detect");
        model_push(code);
        vectors++;
        if (key_valid !== 1'b1 || key_code !== q[0]) begin
            miscompares++;
            $display("FAIL press_head: valid=%b code=%h required valid=1 code=%h", key_valid, key_code, q[0]);
        end
        vectors++;
        if (overflow !== ovf_exp) begin
            miscompares++;
            $display("FAIL press_overflow: got %b required %b", overflow, ovf_exp);
        end
        keys = '0;
        wait_pressed(1'b0, 200, "release_detect");
    endtask

    task automatic pop_check();
        if (q.size() == 0) begin
            key_rd = 1'b1;
            tick();
            key_rd = 1'b0;
            vectors++;
            if (key_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL empty_read: key_valid=%b required 0", key_valid);
            end
        end else begin
            vectors++;
            if (key_valid !== 1'b1 || key_code !== q[0]) begin
                miscompares++;
                $display("FAIL pop_head: valid=%b code=%h required valid=1 code=%h", key_valid, key_code, q[0]);
            end
            key_rd = 1'b1;
            tick();
            key_rd = 1'b0;
            void'(q.pop_front());
        end
    endtask

    task automatic drain_check();
        while (q.size() > 0) pop_check();
        vectors++;
        if (key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty: key_valid=%b required 0", key_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        keys = '0;
        key_rd = 1'b0;
        repeat (3) tick();
        vectors++;
        if (col !== 4'b0000 || key_code !== 4'h0 || key_valid !== 1'b0 ||
            pressed !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: col=%b code=%h valid=%b pressed=%b ovf=%b required 0000 0 0 0 0",
                     col, key_code, key_valid, pressed, overflow);
        end
        rst = 1'b0;
        q.delete();
        ovf_exp = 1'b0;
    endtask

    task automatic test_single_key();
        do_reset();
        keys[key_pos(4'h8)] = 1'b1;
        wait_pressed(1'b1, 200, "key8_press");
        q.push_back(4'h8);
        vectors++;
        if (key_code !== 4'h8 || key_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL key8_code: code=%h valid=%b required 8 1", key_code, key_valid);
        end
        keys = '0;
        // release needs a HELD sample plus DB release samples: not done within DB*SD-1 cycles
        repeat (DB*SD - 1) tick();
        vectors++;
        if (pressed !== 1'b1) begin
            miscompares++;
            $display("FAIL key8_release_early: pressed=%b required 1", pressed);
        end
        wait_pressed(1'b0, 20 - (DB*SD - 1), "key8_release");
        drain_check();
    endtask

    task automatic test_glitch();
        int n;
        do_reset();
        keys[key_pos(4'hA)] = 1'b1;
        n = 0;
        while (col !== 4'b1110 && n < 50) begin tick(); n++; end
        vectors++;
        if (col !== 4'b1110) begin
            miscompares++;
            $display("FAIL glitch_scan_start: col=%b required 1110", col);
        end
        repeat (SD) tick();
        keys = '0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (pressed !== 1'b0 || key_valid !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL glitch_no_push: pressed=%b valid=%b required 0 0", pressed, key_valid);
                break;
            end
        end
        vectors++;
        if (col !== 4'b0000 || key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_idle: col=%b valid=%b required 0000 0", col, key_valid);
        end
    endtask

    task automatic test_two_rows();
        logic [3:0] exp_seq [4];
        logic [3:0] prev;
        int         k, n;
        do_reset();
        exp_seq[0] = 4'b1101; exp_seq[1] = 4'b1011;
        exp_seq[2] = 4'b0111; exp_seq[3] = 4'b0000;
        keys[13] = 1'b1;
        keys[5]  = 1'b1;
        n = 0;
        while (col !== 4'b1110 && n < 50) begin tick(); n++; end
        prev = col;
        k = 0;
        n = 0;
        while (k < 4 && n < 40) begin
            tick();
            n++;
            if (col !== prev) begin
                vectors++;
                if (col !== exp_seq[k]) begin
                    miscompares++;
                    $display("FAIL two_rows_col%0d: col=%b required %b", k, col, exp_seq[k]);
                end
                prev = col;
                k++;
            end
        end
        vectors++;
        if (k != 4 || pressed !== 1'b0 || key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL two_rows_end: steps=%0d pressed=%b valid=%b required 4 0 0", k, pressed, key_valid);
        end
        keys = '0;
        repeat (2*SD) tick();
    endtask

    task automatic test_overflow();
        logic [3:0] seq [5];
        do_reset();
        seq[0] = 4'h1; seq[1] = 4'h5; seq[2] = 4'h9; seq[3] = 4'hD; seq[4] = 4'hE;
        for (int i = 0; i < 5; i++) press_key(seq[i]);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: got %b required 1", overflow);
        end
        drain_check();
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        for (int i = 0; i < 4; i++) press_key(4'($urandom_range(0, 15)));
        keys[key_pos(4'h0)] = 1'b1;
        n = 0;
        while (col !== 4'b1101 && n < 50) begin tick(); n++; end
        // push lands on the 4th sample edge after column 1 is entered
        repeat (4*SD - 1) tick();
        key_rd = 1'b1;
        vectors++;
        if (key_code !== q[0] || key_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_head: code=%h valid=%b required %h 1", key_code, key_valid, q[0]);
        end
        tick();
        key_rd = 1'b0;
        void'(q.pop_front());
        q.push_back(4'h0);
        vectors++;
        if (pressed !== 1'b1 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pushpop: pressed=%b ovf=%b required 1 0", pressed, overflow);
        end
        keys = '0;
        wait_pressed(1'b0, 200, "key0_release");
        drain_check();
    endtask

    task automatic test_reset_in_held();
        do_reset();
        keys[key_pos(4'h7)] = 1'b1;
        wait_pressed(1'b1, 200, "key7_press");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        ovf_exp = 1'b0;
        vectors++;
        if (col !== 4'b0000 || pressed !== 1'b0 || key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL held_reset: col=%b pressed=%b valid=%b required 0000 0 0", col, pressed, key_valid);
        end
        wait_pressed(1'b1, 200, "key7_redetect");
        q.push_back(4'h7);
        vectors++;
        if (key_code !== 4'h7 || key_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL key7_again: code=%h valid=%b required 7 1", key_code, key_valid);
        end
        keys = '0;
        wait_pressed(1'b0, 200, "key7_release");
        drain_check();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            press_key(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) pop_check();
        end
        vectors++;
        if (overflow !== ovf_exp) begin
            miscompares++;
            $display("FAIL random_overflow: got %b required %b", overflow, ovf_exp);
        end
        drain_check();
        pop_check();
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_glitch();
        test_two_rows();
        test_overflow();
        test_back_to_back();
        test_reset_in_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
